// File: rtl/sm83_irq_pkg.sv
// Shared types, default vector map and reference priority encoder for the
// sm83 interrupt dispatch block.
package sm83_irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT1  = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PUSH_H = 3'd3,
    ST_PUSH_L = 3'd4,
    ST_JUMP   = 3'd5
  } disp_state_e;

  localparam logic [15:0] VEC_BASE_DEFAULT   = 16'h0040;
  localparam logic [15:0] VEC_STRIDE_DEFAULT = 16'd8;

  // Reference encoder is sized for the largest source count the core supports.
  localparam int PRIO_MAX   = 8;
  localparam int PRIO_IDX_W = 3;

  // Returns {valid, idx} where idx is the lowest set bit of pending.
  function automatic logic [PRIO_IDX_W:0] prio_encode(input logic [PRIO_MAX-1:0] pending);
    logic [PRIO_IDX_W:0] r;
    r = '0;
    for (int i = PRIO_MAX - 1; i >= 0; i--) begin
      if (pending[i]) r = {1'b1, i[PRIO_IDX_W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/sm83_irq_prio.sv
// Lowest-bit-wins priority encoder: one-hot grant, binary index and valid.
// Built as a ripple of grant/seen terms so each stage is a single and-or cell.
import sm83_irq_pkg::*;

module sm83_irq_prio #(
  parameter int NUM_IRQ = 5,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_IRQ-1:0] pending_i,
  output logic [NUM_IRQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic seen;

  always_comb begin
    seen    = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      grant_o[i] = pending_i[i] & ~seen;
      seen       = seen | pending_i[i];
      if (grant_o[i]) idx_o = IDX_W'(i);
    end
    valid_o = seen;
  end

endmodule

// File: rtl/sm83_irq_dispatch.sv
// Interrupt arbiter and 5-M-cycle dispatch sequencer; also owns IME and HALT wake.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_IDLE   | normal execution, watching for a takeable IRQ
//   ST_WAIT1  | first internal wait M-cycle
//   ST_WAIT2  | second internal wait M-cycle
//   ST_PUSH_H | push PC[15:8]; arbitration sampled on exit
//   ST_PUSH_L | push PC[7:0]
//   ST_JUMP   | load PC from the sampled vector
import sm83_irq_pkg::*;

module sm83_irq_dispatch #(
  parameter int          NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEFAULT,
  parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic               mcyc_i,
  input  logic               insn_end_i,
  input  logic               ei_i,
  input  logic               di_i,
  input  logic               reti_i,
  input  logic               halted_i,
  input  logic [NUM_IRQ-1:0] if_req_i,
  input  logic [NUM_IRQ-1:0] ie_i,
  output logic               ime_o,
  output logic               busy_o,
  output logic               push_hi_o,
  output logic               push_lo_o,
  output logic               load_pc_o,
  output logic [15:0]        vector_o,
  output logic [NUM_IRQ-1:0] ack_o,
  output logic               wake_o
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  disp_state_e state_q, state_d;
  logic        ime_q, ime_d;
  logic        ime_pend_q, ime_pend_d;
  logic        ei_done_q, ei_done_d;
  logic [15:0] vector_q, vector_d;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] grant;
  logic [IDX_W-1:0]   prio_idx;
  logic               prio_valid;
  logic               any;

  assign pending = if_req_i & ie_i;
  assign any     = |pending;

  sm83_irq_prio #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_prio (
    .pending_i (pending),
    .grant_o   (grant),
    .idx_o     (prio_idx),
    .valid_o   (prio_valid)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= ST_IDLE;
      ime_q      <= 1'b0;
      ime_pend_q <= 1'b0;
      ei_done_q  <= 1'b0;
      vector_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      ime_q      <= ime_d;
      ime_pend_q <= ime_pend_d;
      ei_done_q  <= ei_done_d;
      vector_q   <= vector_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ime_d      = ime_q;
    ime_pend_d = ime_pend_q;
    ei_done_d  = ei_done_q;
    vector_d   = vector_q;
    ack_o      = '0;

    if (mcyc_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ime_q && any && (insn_end_i || halted_i)) begin
            state_d    = ST_WAIT1;
            ime_d      = 1'b0;
            ime_pend_d = 1'b0;
            ei_done_d  = 1'b0;
          end else if (di_i) begin
            ime_d      = 1'b0;
            ime_pend_d = 1'b0;
            ei_done_d  = 1'b0;
          end else begin
            if (reti_i) ime_d = 1'b1;
            // ei_done marks that the EI instruction itself has already ended.
            if (ei_i) begin
              ime_pend_d = 1'b1;
              ei_done_d  = insn_end_i;
            end else if (ime_pend_q && insn_end_i) begin
              if (ei_done_q) begin
                ime_d      = 1'b1;
                ime_pend_d = 1'b0;
                ei_done_d  = 1'b0;
              end else begin
                ei_done_d  = 1'b1;
              end
            end
          end
        end
        ST_WAIT1:  state_d = ST_WAIT2;
        ST_WAIT2:  state_d = ST_PUSH_H;
        ST_PUSH_H: begin
          state_d  = ST_PUSH_L;
          ack_o    = grant;
          vector_d = prio_valid ? (VEC_BASE + 16'(prio_idx) * VEC_STRIDE) : 16'h0000;
        end
        ST_PUSH_L: state_d = ST_JUMP;
        ST_JUMP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign ime_o     = ime_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign push_hi_o = (state_q == ST_PUSH_H);
  assign push_lo_o = (state_q == ST_PUSH_L);
  assign load_pc_o = (state_q == ST_JUMP);
  assign vector_o  = vector_q;
  assign wake_o    = halted_i & any;

  prio_matches_ref: assert property (@(posedge clk_i) disable iff (!nreset_i)
    {prio_valid, PRIO_IDX_W'(prio_idx)} == prio_encode(PRIO_MAX'(pending)));

endmodule

// File: tb/tb_sm83_irq_dispatch.sv
// Directed bench for sm83_irq_dispatch with a per-cycle behavioural model.
module tb_sm83_irq_dispatch;

  logic       clk = 1'b0;
  logic       nreset, mcyc, insn_end, ei, di, reti, halted;
  logic [4:0] if_req, ie;
  logic       ime, busy, push_hi, push_lo, load_pc, wake;
  logic [15:0] vector;
  logic [4:0] ack;
  logic [4:0] last_ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sm83_irq_dispatch dut (
    .clk_i      (clk),
    .nreset_i   (nreset),
    .mcyc_i     (mcyc),
    .insn_end_i (insn_end),
    .ei_i       (ei),
    .di_i       (di),
    .reti_i     (reti),
    .halted_i   (halted),
    .if_req_i   (if_req),
    .ie_i       (ie),
    .ime_o      (ime),
    .busy_o     (busy),
    .push_hi_o  (push_hi),
    .push_lo_o  (push_lo),
    .load_pc_o  (load_pc),
    .vector_o   (vector),
    .ack_o      (ack),
    .wake_o     (wake)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int low_idx(input logic [4:0] p);
    for (int i = 0; i < 5; i++) if (p[i]) return i;
    return -1;
  endfunction

  // Model: m_phase is the dispatch M-cycle number (0 = not dispatching),
  // m_left counts instruction ends still needed before EI takes effect.
  int          m_phase;
  logic        m_ime;
  int          m_left;
  logic [15:0] m_vec;

  always @(posedge clk or negedge nreset) begin : model
    logic [4:0] p;
    int k;
    if (!nreset) begin
      m_phase = 0; m_ime = 1'b0; m_left = 0; m_vec = 16'h0000;
    end else if (mcyc) begin
      p = if_req & ie;
      if (m_phase == 0) begin
        if (m_ime && p != 5'd0 && (insn_end || halted)) begin
          m_phase = 1; m_ime = 1'b0; m_left = 0;
        end else if (di) begin
          m_ime = 1'b0; m_left = 0;
        end else begin
          if (reti) m_ime = 1'b1;
          if (ei) m_left = insn_end ? 1 : 2;
          else if (m_left > 0 && insn_end) begin
            m_left--;
            if (m_left == 0) m_ime = 1'b1;
          end
        end
      end else begin
        if (m_phase == 3) begin
          k = low_idx(p);
          m_vec = (k < 0) ? 16'h0000 : 16'h0040 + 16'(k * 8);
        end
        m_phase = (m_phase == 5) ? 0 : m_phase + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [4:0] p;
    logic [4:0] eack;
    int k;
    p = if_req & ie;
    k = low_idx(p);
    eack = 5'd0;
    if (nreset && mcyc && m_phase == 3 && k >= 0) eack = 5'(1 << k);
    chk1 ("m_ime",     ime,     m_ime);
    chk1 ("m_busy",    busy,    m_phase != 0);
    chk1 ("m_push_hi", push_hi, m_phase == 3);
    chk1 ("m_push_lo", push_lo, m_phase == 4);
    chk1 ("m_load_pc", load_pc, m_phase == 5);
    chk16("m_vector",  vector,  m_vec);
    chk5 ("m_ack",     ack,     eack);
    chk1 ("m_wake",    wake,    halted && p != 5'd0);
  end

  // One M-cycle: strobe for one clk then one idle clk. Entered and left at posedge+2.
  task automatic mstep(input logic e_end, input logic e, input logic d, input logic r);
    insn_end = e_end; ei = e; di = d; reti = r; mcyc = 1'b1;
    @(negedge clk);
    last_ack = ack;
    @(posedge clk); #2;
    mcyc = 1'b0; insn_end = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0;
    @(posedge clk); #2;
  endtask

  // Called with the DUT in the first dispatch M-cycle.
  task automatic run_dispatch(input string tag, input logic [15:0] exp_vec,
                              input logic [4:0] exp_ack, input logic cancel);
    for (int k = 1; k <= 5; k++) begin
      if (cancel && k == 3) ie = 5'd0;
      chk1({tag, "_busy"},    busy,    1'b1);
      chk1({tag, "_push_hi"}, push_hi, k == 3);
      chk1({tag, "_push_lo"}, push_lo, k == 4);
      chk1({tag, "_load_pc"}, load_pc, k == 5);
      mstep(1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 3) begin
        chk5 ({tag, "_ack"},    last_ack, exp_ack);
        chk16({tag, "_vector"}, vector,   exp_vec);
      end
    end
    chk1 ({tag, "_done_busy"}, busy,   1'b0);
    chk1 ({tag, "_done_ime"},  ime,    1'b0);
    chk16({tag, "_hold_vec"},  vector, exp_vec);
  endtask

  initial begin
    nreset = 1'b0; mcyc = 1'b0; insn_end = 1'b0; ei = 1'b0; di = 1'b0;
    reti = 1'b0; halted = 1'b0; if_req = 5'd0; ie = 5'd0; last_ack = 5'd0;
    repeat (3) @(posedge clk);
    #2 nreset = 1'b1;
    @(posedge clk); #2;

    chk1 ("rst_ime",    ime,    1'b0);
    chk1 ("rst_busy",   busy,   1'b0);
    chk16("rst_vector", vector, 16'h0000);
    chk5 ("rst_ack",    ack,    5'd0);

    // EI ending with insn_end: one more instruction before IME sets
    mstep(1'b1, 1'b1, 1'b0, 1'b0);
    chk1("ei_delay1", ime, 1'b0);
    mstep(1'b1, 1'b0, 1'b0, 1'b0);
    chk1("ei_delay2", ime, 1'b1);

    mstep(1'b0, 1'b0, 1'b1, 1'b0);
    chk1("di_clear", ime, 1'b0);
    mstep(1'b1, 1'b1, 1'b1, 1'b0);
    mstep(1'b1, 1'b0, 1'b0, 1'b0);
    mstep(1'b1, 1'b0, 1'b0, 1'b0);
    chk1("di_beats_ei", ime, 1'b0);

    // EI before its own insn_end: two instruction ends needed
    mstep(1'b0, 1'b1, 1'b0, 1'b0);
    mstep(1'b1, 1'b0, 1'b0, 1'b0);
    chk1("ei_long1", ime, 1'b0);
    mstep(1'b1, 1'b0, 1'b0, 1'b0);
    chk1("ei_long2", ime, 1'b1);

    // Basic dispatch of source 2
    ie = 5'h1F; if_req = 5'b00100;
    mstep(1'b1, 1'b0, 1'b0, 1'b0);
    chk1("basic_start_ime", ime, 1'b0);
    run_dispatch("basic", 16'h0050, 5'b00100, 1'b0);
    if_req = 5'd0;

    mstep(1'b0, 1'b0, 1'b0, 1'b1);
    chk1("reti_ime", ime, 1'b1);

    // Priority: source 1 beats 2 and 4
    if_req = 5'b10110;
    mstep(1'b1, 1'b0, 1'b0, 1'b0);
    run_dispatch("prio", 16'h0048, 5'b00010, 1'b0);
    if_req = 5'd0;

    // Late cancel: IE cleared during the high push
    mstep(1'b0, 1'b0, 1'b0, 1'b1);
    if_req = 5'b00100; ie = 5'h1F;
    mstep(1'b1, 1'b0, 1'b0, 1'b0);
    run_dispatch("cancel", 16'h0000, 5'b00000, 1'b1);
    if_req = 5'd0; ie = 5'h1F;

    // HALT wake without IME, then HALT-triggered dispatch
    halted = 1'b1; if_req = 5'b00001; ie = 5'b00001;
    #1;
    chk1("halt_wake", wake, 1'b1);
    mstep(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("halt_no_disp", busy, 1'b0);
    mstep(1'b0, 1'b0, 1'b0, 1'b1);
    chk1("halt_reti_busy", busy, 1'b0);
    chk1("halt_reti_ime",  ime,  1'b1);
    mstep(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("halt_disp_busy", busy, 1'b1);
    run_dispatch("halt", 16'h0040, 5'b00001, 1'b0);
    halted = 1'b0; if_req = 5'd0; ie = 5'h1F;

    // Async reset in PUSH_L
    mstep(1'b0, 1'b0, 1'b0, 1'b1);
    if_req = 5'b00100;
    mstep(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) mstep(1'b0, 1'b0, 1'b0, 1'b0);
    chk1 ("pre_rst_push_lo", push_lo, 1'b1);
    chk16("pre_rst_vector",  vector,  16'h0050);
    nreset = 1'b0;
    #1;
    chk1 ("arst_busy",    busy,    1'b0);
    chk1 ("arst_push_lo", push_lo, 1'b0);
    chk1 ("arst_load_pc", load_pc, 1'b0);
    chk1 ("arst_ime",     ime,     1'b0);
    chk16("arst_vector",  vector,  16'h0000);
    chk5 ("arst_ack",     ack,     5'd0);
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
    @(posedge clk); #2;
    mstep(1'b0, 1'b0, 1'b0, 1'b0);
    chk1 ("post_rst_busy",   busy,   1'b0);
    chk16("post_rst_vector", vector, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
